// File: rtl/video_pkg.sv
// Shared types and defaults for the video input path: FSM state encodings,
// bank identifier and the default line/band geometry.
package video_pkg;

    localparam int H_MAX_DEF      = 1280;
    localparam int BAND_LINES_DEF = 45;

    typedef logic bank_t;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_OFFER = 2'd1,
        R_BUSY  = 2'd2
    } rd_state_t;

    // Snapshot of both FSMs, kept as one probe point for checkers.
    typedef struct packed {
        wr_state_t wr_state;
        rd_state_t rd_state;
    } fsm_dbg_t;

    function automatic bank_t other_bank(input bank_t b);
        return ~b;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Registers one sync input and produces single-cycle rise/fall pulses
// relative to the previous cycle's level.
module sync_edge
(
    input  logic clk,
    input  logic reset_n,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/line_bank_ctrl.sv
// Ping-pong line-buffer controller: counts lines/pixels from vs/hs/de, fills
// one of two banks per line and offers each completed bank to the reader.
module line_bank_ctrl
    import video_pkg::*;
#(
    parameter int H_MAX      = H_MAX_DEF,
    parameter int ADDR_W     = 11,
    parameter int BAND_LINES = BAND_LINES_DEF,
    parameter int LINE_W     = 12
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vs,
    input  logic              hs,
    input  logic              de,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [LINE_W-1:0] line_cnt,
    output logic              frame_start,
    output logic              rd_req,
    output logic              rd_bank,
    output logic [ADDR_W:0]   rd_len,
    input  logic              rd_ack,
    input  logic              rd_done,
    output logic              overrun,
    output logic [15:0]       ovr_cnt
);

    localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W + 1)'(H_MAX);
    localparam logic [LINE_W-1:0] LINE_TOP = LINE_W'(BAND_LINES);

    logic hs_rise, hs_fall;
    logic vs_rise, vs_fall;

    sync_edge u_hs_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (hs),
        .rise    (hs_rise),
        .fall    (hs_fall)
    );

    sync_edge u_vs_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (vs),
        .rise    (vs_rise),
        .fall    (vs_fall)
    );

    wr_state_t          wr_state, wr_state_nxt;
    rd_state_t          rd_state, rd_state_nxt;
    logic [ADDR_W:0]    fill_len, fill_len_nxt;
    bank_t              cur_bank, cur_bank_nxt;
    logic [LINE_W-1:0]  line_nxt;
    logic               pix_wr;
    logic [ADDR_W-1:0]  pix_addr;
    logic               handoff;
    logic               drop_line;
    logic               other_free;
    fsm_dbg_t           dbg_state;
    logic               unused_sig;

    assign dbg_state  = '{wr_state: wr_state, rd_state: rd_state};
    assign unused_sig = ^{hs_fall, vs_rise, dbg_state};

    // ------------------------------------------------------------------
    // Line counter and frame-start pulse
    // ------------------------------------------------------------------
    always_comb begin
        line_nxt = line_cnt;
        if (!vs) begin
            line_nxt = '0;
        end else if (hs_rise) begin
            line_nxt = (line_cnt == LINE_TOP) ? LINE_W'(1) : line_cnt + LINE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_cnt    <= '0;
            frame_start <= 1'b0;
        end else begin
            line_cnt    <= line_nxt;
            frame_start <= (line_cnt == '0) && (line_nxt != '0);
        end
    end

    // A release arriving on the hs-rise cycle frees the bank just in time.
    assign other_free = (rd_state == R_IDLE) || ((rd_state == R_BUSY) && rd_done);

    // ------------------------------------------------------------------
    // Write FSM: line boundary first, then the pixel of this cycle, so a
    // pixel coinciding with hs lands at address 0 of the new line.
    // ------------------------------------------------------------------
    always_comb begin
        wr_state_nxt = wr_state;
        fill_len_nxt = fill_len;
        cur_bank_nxt = cur_bank;
        pix_wr       = 1'b0;
        pix_addr     = '0;
        handoff      = 1'b0;
        drop_line    = 1'b0;
        if (vs_fall) begin
            wr_state_nxt = W_IDLE;
            fill_len_nxt = '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (vs) begin
                        wr_state_nxt = W_FILL;
                    end
                end
                W_FILL: begin
                    if (hs_rise) begin
                        fill_len_nxt = '0;
                        if (fill_len != '0) begin
                            if (other_free) begin
                                handoff      = 1'b1;
                                cur_bank_nxt = other_bank(cur_bank);
                            end else begin
                                drop_line = 1'b1;
                            end
                        end
                    end
                    // Pixels past the bank depth are discarded, never wrapped.
                    if (de && (fill_len_nxt < LEN_MAX)) begin
                        pix_wr       = 1'b1;
                        pix_addr     = fill_len_nxt[ADDR_W-1:0];
                        fill_len_nxt = fill_len_nxt + (ADDR_W + 1)'(1);
                    end
                end
                default: wr_state_nxt = W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read FSM: one outstanding bank at a time.
    // ------------------------------------------------------------------
    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE: begin
                if (handoff) begin
                    rd_state_nxt = R_OFFER;
                end
            end
            R_OFFER: begin
                if (rd_ack) begin
                    rd_state_nxt = R_BUSY;
                end
            end
            R_BUSY: begin
                if (rd_done) begin
                    rd_state_nxt = handoff ? R_OFFER : R_IDLE;
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
            fill_len <= '0;
            cur_bank <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            rd_bank  <= 1'b0;
            rd_len   <= '0;
            overrun  <= 1'b0;
            ovr_cnt  <= '0;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
            fill_len <= fill_len_nxt;
            cur_bank <= cur_bank_nxt;
            wr_en    <= pix_wr;
            wr_addr  <= pix_addr;
            overrun  <= drop_line;
            if (drop_line && (ovr_cnt != '1)) begin
                ovr_cnt <= ovr_cnt + 16'd1;
            end
            if (handoff) begin
                rd_bank <= cur_bank;
                rd_len  <= fill_len;
            end
        end
    end

    assign wr_bank = cur_bank;
    assign rd_req  = (rd_state == R_OFFER);

endmodule
